// File: rtl/i2s_master.sv
// i2s_master: codec-side I2S bus master, 24-bit stereo in 64-bit frames.
// Generates bclk/lrclk from clk, shifts TX samples out MSB first.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   enabled                run/stop request, honoured at frame boundaries
//   tx_left/right/valid    sample pair offer; tx_ready = holding empty
//   bclk, lrclk, sdata_o   I2S bus outputs (lrclk 0 = left slot)
//   sdata_i                serial input (receive path only)
//   frame_start, underrun  one-cycle pulses at the entry to pos 0
//   rx_left/right/valid    last received pair (receive path only)
//
// Optional receive path: define I2S_MASTER_RX_EN to compile it in.
// Without it sdata_i is ignored and the rx outputs are tied to 0.

module i2s_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enabled,
  input  logic [23:0] tx_left,
  input  logic [23:0] tx_right,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata_o,
  input  logic        sdata_i,
  output logic        frame_start,
  output logic        underrun,
  output logic [23:0] rx_left,
  output logic [23:0] rx_right,
  output logic        rx_valid
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_TC = DW'(CLK_DIV - 1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  state_e      state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic        bclk_q, bclk_d;
  logic        lrclk_q, lrclk_d;
  logic        sdata_q, sdata_d;
  logic [5:0]  pos_q, pos_d;
  logic        fs_q, fs_d;
  logic        ur_q, ur_d;
  logic        hold_full_q, hold_full_d;
  logic [23:0] hold_l_q, hold_l_d;
  logic [23:0] hold_r_q, hold_r_d;
  logic [23:0] sh_l_q, sh_l_d;
  logic [23:0] sh_r_q, sh_r_d;
  logic        rise;
  logic        fall;
  logic        load;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bclk_d      = bclk_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    pos_d       = pos_q;
    fs_d        = 1'b0;
    ur_d        = 1'b0;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    sh_l_d      = sh_l_q;
    sh_r_d      = sh_r_q;
    rise        = 1'b0;
    fall        = 1'b0;
    load        = 1'b0;

    // The divider runs from the first enabled cycle out of idle.
    if (state_q == ST_RUN || enabled) begin
      state_d = ST_RUN;
      if (div_q == DIV_TC) begin
        div_d  = '0;
        bclk_d = ~bclk_q;
        rise   = ~bclk_q;
        fall   = bclk_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    if (fall) begin
      if (pos_q == 6'd63 && !enabled) begin
        // Frame finished with stop requested: park the bus.
        state_d = ST_IDLE;
        div_d   = '0;
        bclk_d  = 1'b0;
        lrclk_d = 1'b1;
        sdata_d = 1'b0;
      end else begin
        pos_d   = pos_q + 6'd1;
        lrclk_d = pos_d[5];
        sdata_d = 1'b0;
        if (pos_d == 6'd0) begin
          load = 1'b1;
          fs_d = 1'b1;
        end else if (pos_d <= 6'd24) begin
          sdata_d = sh_l_q[23];
          sh_l_d  = {sh_l_q[22:0], 1'b0};
        end else if (pos_d >= 6'd33 && pos_d <= 6'd56) begin
          sdata_d = sh_r_q[23];
          sh_r_d  = {sh_r_q[22:0], 1'b0};
        end
      end
    end

    if (load) begin
      if (hold_full_q) begin
        sh_l_d      = hold_l_q;
        sh_r_d      = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        sh_l_d = '0;
        sh_r_d = '0;
        ur_d   = 1'b1;
      end
    end

    // Ready is a registered copy of "holding empty", so an offer in
    // the load cycle still sees it full and waits.
    if (tx_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_l_d    = tx_left;
      hold_r_d    = tx_right;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b1;
      sdata_q     <= 1'b0;
      pos_q       <= 6'd63;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      pos_q       <= pos_d;
      fs_q        <= fs_d;
      ur_q        <= ur_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      sh_l_q      <= sh_l_d;
      sh_r_q      <= sh_r_d;
    end
  end

  assign tx_ready    = ~hold_full_q;
  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign sdata_o     = sdata_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

`ifdef I2S_MASTER_RX_EN
  logic [23:0] cap_l_q, cap_l_d;
  logic [23:0] cap_r_q, cap_r_d;
  logic [23:0] rxl_q, rxl_d;
  logic [23:0] rxr_q, rxr_d;
  logic        rxv_q, rxv_d;
  logic        rx_ok_q, rx_ok_d;

  always_comb begin
    cap_l_d = cap_l_q;
    cap_r_d = cap_r_q;
    rxl_d   = rxl_q;
    rxr_d   = rxr_q;
    rxv_d   = 1'b0;
    rx_ok_d = rx_ok_q;

    if (rise) begin
      if (pos_q >= 6'd1 && pos_q <= 6'd24) begin
        cap_l_d = {cap_l_q[22:0], sdata_i};
      end else if (pos_q >= 6'd33 && pos_q <= 6'd56) begin
        cap_r_d = {cap_r_q[22:0], sdata_i};
      end
    end

    // rx_ok marks that a full frame has been captured since start.
    if (state_q == ST_IDLE) begin
      rx_ok_d = 1'b0;
    end

    if (load) begin
      rx_ok_d = 1'b1;
      if (rx_ok_q) begin
        rxl_d = cap_l_q;
        rxr_d = cap_r_q;
        rxv_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_l_q <= '0;
      cap_r_q <= '0;
      rxl_q   <= '0;
      rxr_q   <= '0;
      rxv_q   <= 1'b0;
      rx_ok_q <= 1'b0;
    end else begin
      cap_l_q <= cap_l_d;
      cap_r_q <= cap_r_d;
      rxl_q   <= rxl_d;
      rxr_q   <= rxr_d;
      rxv_q   <= rxv_d;
      rx_ok_q <= rx_ok_d;
    end
  end

  assign rx_left  = rxl_q;
  assign rx_right = rxr_q;
  assign rx_valid = rxv_q;
`else
  logic unused_rx;
  assign unused_rx = sdata_i ^ rise;
  assign rx_left   = '0;
  assign rx_right  = '0;
  assign rx_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_master.sv
// tb_i2s_master: scoreboard bench for i2s_master.
// Accepted pairs queue up; a monitor rebuilds each frame and compares.

`timescale 1ns/1ps

module tb_i2s_master;

  localparam int CLK_DIV = 4;
  localparam int FRAME   = 128 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enabled = 1'b0;
  logic [23:0] tx_left = '0;
  logic [23:0] tx_right = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata_o;
  logic        sdata_i;
  logic        frame_start;
  logic        underrun;
  logic [23:0] rx_left;
  logic [23:0] rx_right;
  logic        rx_valid;

  assign sdata_i = sdata_o;

  i2s_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk),
    .reset(reset),
    .enabled(enabled),
    .tx_left(tx_left),
    .tx_right(tx_right),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .bclk(bclk),
    .lrclk(lrclk),
    .sdata_o(sdata_o),
    .sdata_i(sdata_i),
    .frame_start(frame_start),
    .underrun(underrun),
    .rx_left(rx_left),
    .rx_right(rx_right),
    .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    int          stamp;
  } item_t;

  item_t expq[$];

  // Scoreboard input: every accepted pair, stamped with its edge.
  always @(posedge clk) begin
    if (!reset && tx_valid && tx_ready)
      expq.push_back(item_t'{tx_left, tx_right, cyc + 1});
  end

  logic        collecting = 1'b0;
  logic        have_last = 1'b0;
  logic        bclk_prev = 1'b0;
  int          last_fs = 0;
  int          nbits = 0;
  logic [63:0] got_d;
  logic [63:0] got_lr;
  logic [23:0] cur_l = '0;
  logic [23:0] cur_r = '0;
  logic        exp_ur;
  logic        exp_rxv;

  // Monitor: expected frame = {0, L, 7x0, 0, R, 7x0}, lrclk = 32x0,32x1.
  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
      collecting = 1'b0;
      have_last  = 1'b0;
    end else begin
      exp_ur  = 1'b0;
      exp_rxv = 1'b0;
      if (frame_start) begin
`ifdef I2S_MASTER_RX_EN
        exp_rxv = have_last && (cyc - last_fs == FRAME);
        if (exp_rxv) begin
          chk("rx_left", 64'(rx_left), 64'(cur_l));
          chk("rx_right", 64'(rx_right), 64'(cur_r));
        end
`else
        chk("rx_left_tied", 64'(rx_left), 64'd0);
`endif
        if (expq.size() > 0 && expq[0].stamp < cyc) begin
          cur_l = expq[0].l;
          cur_r = expq[0].r;
          void'(expq.pop_front());
        end else begin
          cur_l  = '0;
          cur_r  = '0;
          exp_ur = 1'b1;
        end
        have_last  = 1'b1;
        last_fs    = cyc;
        collecting = 1'b1;
        nbits      = 0;
        got_d      = '0;
        got_lr     = '0;
      end
      if (underrun || frame_start)
        chk("underrun", 64'(underrun), 64'(exp_ur));
      if (rx_valid || frame_start)
        chk("rx_valid", 64'(rx_valid), 64'(exp_rxv));
      if (collecting && bclk_prev && !bclk) begin
        got_d  = {got_d[62:0], sdata_o};
        got_lr = {got_lr[62:0], lrclk};
        nbits++;
        if (nbits == 64) begin
          chk("frame_data", got_d,
              {1'b0, cur_l, 7'd0, 1'b0, cur_r, 7'd0});
          chk("frame_lrclk", got_lr, {32'h0, 32'hFFFF_FFFF});
          collecting = 1'b0;
        end
      end
    end
    bclk_prev = bclk;
  end

  task automatic wait_ev(input int sel, input int budget, output int c);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel == 0 && bclk) || (sel == 1 && frame_start) ||
          (sel == 2 && lrclk)) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic check_reset();
    chk("rst_bclk", 64'(bclk), 64'd0);
    chk("rst_lrclk", 64'(lrclk), 64'd1);
    chk("rst_sdata", 64'(sdata_o), 64'd0);
    chk("rst_tx_ready", 64'(tx_ready), 64'd1);
    chk("rst_frame_start", 64'(frame_start), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_rx_valid", 64'(rx_valid), 64'd0);
    chk("rst_rx_left", 64'(rx_left), 64'd0);
    chk("rst_rx_right", 64'(rx_right), 64'd0);
  endtask

  task automatic check_timing();
    int c;
    wait_ev(0, 100, c);
    chk("first_bclk_rise", 64'(c), 64'(CLK_DIV));
    wait_ev(1, 100, c);
    chk("first_frame_start", 64'(c), 64'(2 * CLK_DIV));
    chk("lrclk_fall", 64'(lrclk), 64'd0);
    @(negedge clk);
    chk("tx_ready_after_fs", 64'(tx_ready), 64'd1);
    wait_ev(2, FRAME, c);
    chk("lrclk_rise", 64'(c), 64'(2 * CLK_DIV + 64 * CLK_DIV));
    wait_ev(1, FRAME, c);
    chk("second_frame_start", 64'(c), 64'(2 * CLK_DIV + FRAME));
  endtask

  task automatic send(input logic [23:0] l, input logic [23:0] r);
    logic rdy;
    int   n;
    n        = 0;
    tx_left  = l;
    tx_right = r;
    tx_valid = 1'b1;
    do begin
      rdy = tx_ready;
      @(negedge clk);
      n++;
    end while (!rdy && n < 3000);
    tx_valid = 1'b0;
    chk("send_accept", 64'(rdy), 64'd1);
  endtask

  initial begin
    int c;
    int c0;
    int bad;
    int sel;
    repeat (3) @(negedge clk);
    check_reset();

    enabled = 1'b1;
    reset   = 1'b0;
    send(24'hA5A5A5, 24'h123456);
    check_timing();

    repeat (100) @(negedge clk);
    enabled = 1'b0;
    repeat (FRAME + 50) @(negedge clk);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (bclk !== 1'b0 || lrclk !== 1'b1 || sdata_o !== 1'b0 ||
          frame_start || underrun)
        bad++;
    end
    chk("idle_bus", 64'(bad), 64'd0);

    c0 = cyc;
    enabled = 1'b1;
    wait_ev(1, 100, c);
    chk("restart_delay", 64'(c - c0), 64'(2 * CLK_DIV));
    send(24'h800001, 24'h7FFFFF);
    send(24'($urandom), 24'($urandom));
    send(24'($urandom), 24'($urandom));
    send(24'($urandom), 24'($urandom));

    wait_ev(1, 2 * FRAME, c);
    repeat (40 * 2 * CLK_DIV) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset();
    reset = 1'b0;
    check_timing();

    for (int i = 0; i < 24; i++) begin
      sel = int'($urandom_range(9, 0));
      case (sel)
        0, 1, 2, 3, 4, 5: send(24'($urandom), 24'($urandom));
        6, 7: repeat ($urandom_range(800, 100)) @(negedge clk);
        default: begin
          enabled = 1'b0;
          repeat ($urandom_range(1500, 50)) @(negedge clk);
          enabled = 1'b1;
        end
      endcase
    end
    repeat (2 * FRAME + 16) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
